// File: rtl/dpll_pkg.sv
// Shared types and defaults for the DPLL phase detector / loop filter front end.
package dpll_pkg;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_EVAL      = 3'd1,
    ST_PULSE_ADD = 3'd2,
    ST_PULSE_SUB = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned K_DEF           = 8;
  localparam int unsigned ACC_W_DEF       = 8;
  localparam int unsigned HOLDOFF_DEF     = 4;
  localparam int unsigned LOCK_EDGES_DEF  = 16;

  // Narrowest signed accumulator width able to hold +/-k.
  function automatic int unsigned acc_w_for(input int unsigned k);
    return $clog2(k + 1) + 1;
  endfunction

endpackage

// File: rtl/dpll_phase_filter_if.sv
// Bundle between the reference/DCO side and the phase filter's correction outputs.
interface dpll_phase_filter_if
  import dpll_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
);

  logic                    ref_in;
  logic                    dco_clk;
  logic                    add;
  logic                    sub;
  logic signed [ACC_W-1:0] acc_mon;
  logic                    lock;

  modport master (
    output ref_in, dco_clk,
    input  add, sub, acc_mon, lock
  );

  modport slave (
    input  ref_in, dco_clk,
    output add, sub, acc_mon, lock
  );

endinterface

// File: rtl/dpll_sync_edge.sv
// N-flop synchronizer for an asynchronous input with a one-cycle rising-edge strobe.
module dpll_sync_edge #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_c_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign rise_c_o = sync_q[N-1] & ~prev_q;

endmodule

// File: rtl/dpll_phase_filter.sv
// Bang-bang phase detector + K-counter loop filter driving DCO add/sub pulses.
// Optional lock detector built when DPLL_LOCK_DET_EN is defined.
module dpll_phase_filter
  import dpll_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned K           = K_DEF,
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned HOLDOFF     = HOLDOFF_DEF,
  parameter int unsigned LOCK_EDGES  = LOCK_EDGES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  dpll_phase_filter_if.slave  bus
);

  localparam int unsigned DLY_W     = SYNC_STAGES + 1;
  localparam int unsigned HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam logic signed [ACC_W-1:0] K_POS   = ACC_W'(K);
  localparam logic signed [ACC_W-1:0] K_NEG   = -K_POS;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic                    ref_rise_c;
  logic [DLY_W-1:0]        dco_dly_q;
  logic                    dco_d_c;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_step_c;
  logic                    lead_q, lead_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    add_q, add_d;
  logic                    sub_q, sub_d;

  dpll_sync_edge #(.N(SYNC_STAGES)) u_ref_sync (
    .clk      (clk),
    .rst      (rst),
    .d_i      (bus.ref_in),
    .rise_c_o (ref_rise_c)
  );

  // dco_clk delay line aligning its sample with the synchronized ref edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dco_dly_q <= '0;
    else     dco_dly_q <= {dco_dly_q[DLY_W-2:0], bus.dco_clk};
  end

  assign dco_d_c = dco_dly_q[DLY_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
      acc_q   <= '0;
      lead_q  <= 1'b0;
      hold_q  <= '0;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lead_q  <= lead_d;
      hold_q  <= hold_d;
      add_q   <= add_d;
      sub_q   <= sub_d;
    end
  end

  assign acc_step_c = lead_q ? (acc_q - ACC_ONE) : (acc_q + ACC_ONE);

  // Next state plus filter datapath; ref edges outside WAIT are dropped.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    lead_d  = lead_q;
    hold_d  = hold_q;
    case (state_q)
      ST_WAIT: begin
        if (ref_rise_c) begin
          state_d = ST_EVAL;
          lead_d  = dco_d_c;
        end
      end
      ST_EVAL: begin
        acc_d = acc_step_c;
        if (acc_step_c == K_POS) begin
          acc_d   = '0;
          state_d = ST_PULSE_ADD;
        end else if (acc_step_c == K_NEG) begin
          acc_d   = '0;
          state_d = ST_PULSE_SUB;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_PULSE_ADD, ST_PULSE_SUB: begin
        if (HOLDOFF > 0) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_W'(HOLD_LOAD);
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_WAIT;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Pulses registered so they line up exactly with the PULSE_* state cycle
  always_comb begin
    add_d = 1'b0;
    sub_d = 1'b0;
    if (state_d == ST_PULSE_ADD) add_d = 1'b1;
    if (state_d == ST_PULSE_SUB) sub_d = 1'b1;
  end

`ifdef DPLL_LOCK_DET_EN
  localparam int unsigned CNT_W = $clog2(LOCK_EDGES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;

  // Quiet edges build toward lock; any correction pulse restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (add_d || sub_d) begin
      cnt_d = '0;
    end else if ((state_q == ST_EVAL) && (cnt_q != CNT_W'(LOCK_EDGES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    lock_d = (cnt_d == CNT_W'(LOCK_EDGES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

  assign bus.lock = lock_q;
`else
  assign bus.lock = 1'b0;
`endif

  assign bus.add     = add_q;
  assign bus.sub     = sub_q;
  assign bus.acc_mon = acc_q;

endmodule

// File: tb/tb_dpll_phase_filter.sv
// Directed bench for dpll_phase_filter (K=4, HOLDOFF=4, SYNC_STAGES=2).
module tb_dpll_phase_filter;

  logic clk;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  int add_cnt   = 0;
  int sub_cnt   = 0;
  int both_cnt  = 0;
  int cyc       = 0;
  int last_pls  = -1;
  int min_gap   = 1000;
  logic gap_en  = 1'b0;

  dpll_phase_filter_if #(.ACC_W(8)) bus ();

  dpll_phase_filter #(
    .SYNC_STAGES (2),
    .K           (4),
    .ACC_W       (8),
    .HOLDOFF     (4),
    .LOCK_EDGES  (16)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.add === 1'b1) add_cnt <= add_cnt + 1;
    if (bus.sub === 1'b1) sub_cnt <= sub_cnt + 1;
    if ((bus.add === 1'b1) && (bus.sub === 1'b1)) both_cnt <= both_cnt + 1;
    if (!gap_en) begin
      last_pls <= -1;
      min_gap  <= 1000;
    end else if ((bus.add === 1'b1) || (bus.sub === 1'b1)) begin
      if ((last_pls >= 0) && ((cyc - last_pls) < min_gap)) min_gap <= cyc - last_pls;
      last_pls <= cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_add"},  32'(bus.add), 0);
    chk({tag, "_sub"},  32'(bus.sub), 0);
    chk({tag, "_acc"},  32'($signed(bus.acc_mon)), 0);
    chk({tag, "_lock"}, 32'(bus.lock), 0);
  endtask

  // One reference edge: dco level set early, ref high 10 clk then low.
  task automatic ref_edge(input string tag, input logic dco, input int exp_prev, input int exp_acc,
                          input logic exp_add, input logic exp_sub, input logic exp_lock);
    bus.dco_clk = dco;
    repeat (10) tick();
    bus.ref_in = 1'b1;
    repeat (3) tick();
    chk({tag, "_acc_early"}, 32'($signed(bus.acc_mon)), exp_prev);
    tick();
    chk({tag, "_acc"},  32'($signed(bus.acc_mon)), exp_acc);
    chk({tag, "_add"},  32'(bus.add), 32'(exp_add));
    chk({tag, "_sub"},  32'(bus.sub), 32'(exp_sub));
    chk({tag, "_lock"}, 32'(bus.lock), 32'(exp_lock));
    repeat (6) tick();
    bus.ref_in = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk_idle(tag);
    tick();
    bus.ref_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int a0, s0, pulses, hold_left;
    logic stop, exp_lock;

    rst         = 1'b1;
    bus.ref_in  = 1'b0;
    bus.dco_clk = 1'b0;
    repeat (3) tick();
    chk_idle("por");
    rst = 1'b0;
    tick();

    // DCO lagging: acc climbs to K and one add pulse
    a0 = add_cnt; s0 = sub_cnt;
    ref_edge("lag1", 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
    ref_edge("lag2", 1'b0, 1, 2, 1'b0, 1'b0, 1'b0);
    ref_edge("lag3", 1'b0, 2, 3, 1'b0, 1'b0, 1'b0);
    ref_edge("lag4", 1'b0, 3, 0, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    chk("lag_adds", add_cnt - a0, 1);
    chk("lag_subs", sub_cnt - s0, 0);

    // Reset with a non-zero accumulator
    ref_edge("pre1", 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
    ref_edge("pre2", 1'b0, 1, 2, 1'b0, 1'b0, 1'b0);
    do_reset("rst_acc");

    // DCO leading: acc falls to -K and one sub pulse
    a0 = add_cnt; s0 = sub_cnt;
    ref_edge("lead1", 1'b1,  0, -1, 1'b0, 1'b0, 1'b0);
    ref_edge("lead2", 1'b1, -1, -2, 1'b0, 1'b0, 1'b0);
    ref_edge("lead3", 1'b1, -2, -3, 1'b0, 1'b0, 1'b0);
    ref_edge("lead4", 1'b1, -3,  0, 1'b0, 1'b1, 1'b0);
    repeat (10) tick();
    chk("lead_adds", add_cnt - a0, 0);
    chk("lead_subs", sub_cnt - s0, 1);

    // Alternating lag/lead: acc toggles 1/0, no corrections
    a0 = add_cnt; s0 = sub_cnt;
    for (int i = 0; i < 40; i++) begin
`ifdef DPLL_LOCK_DET_EN
      exp_lock = (i + 1 >= 16);
`else
      exp_lock = 1'b0;
`endif
      if (i % 2 == 0) ref_edge("alt_lag",  1'b0, 0, 1, 1'b0, 1'b0, exp_lock);
      else            ref_edge("alt_lead", 1'b1, 1, 0, 1'b0, 1'b0, exp_lock);
    end
    repeat (10) tick();
    chk("alt_adds", add_cnt - a0, 0);
    chk("alt_subs", sub_cnt - s0, 0);

    // Hold-off: ref every 2 clk, dco low; edges inside HOLD must not move acc
    do_reset("rst_hold_pre");
    bus.dco_clk = 1'b0;
    repeat (5) tick();
    gap_en    = 1'b1;
    pulses    = 0;
    hold_left = 0;
    stop      = 1'b0;
    for (int i = 0; (i < 200) && !stop; i++) begin
      bus.ref_in = ~bus.ref_in;
      tick();
      if (hold_left > 0) begin
        chk("hold_acc", 32'($signed(bus.acc_mon)), 0);
        hold_left--;
        if ((pulses == 2) && (hold_left == 2)) stop = 1'b1;
      end
      if (bus.add === 1'b1) begin
        pulses++;
        hold_left = 4;
      end
    end
    chk("hold_pulses", pulses, 2);
    chk("hold_min_gap_ge6", 32'(min_gap >= 6), 1);

    // Reset asserted while in HOLD, then a clean restart from WAIT
    do_reset("rst_mid_hold");
    gap_en = 1'b0;
    ref_edge("post_rst", 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    chk("add_sub_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
